// File: rtl/arcade_input.sv
// Arcade control merger: PS/2 keyboard + joystick per player with SOCD cleaning,
// coin pulse stretching, pause toggle and DIP / game-index capture from the download port.
module arcade_input #(
    parameter int PLAYERS     = 2,
    parameter int DIP_BANKS   = 8,
    parameter int COIN_CYCLES = 16,
    parameter bit SOCD        = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [10:0]            ps2_key,
    input  logic [32*PLAYERS-1:0]  joystick,
    input  logic                   ioctl_wr,
    input  logic [15:0]            ioctl_index,
    input  logic [26:0]            ioctl_addr,
    input  logic [7:0]             ioctl_data,
    output logic [4*PLAYERS-1:0]   joy,
    output logic [3*PLAYERS-1:0]   buttons,
    output logic [PLAYERS-1:0]     start,
    output logic [PLAYERS-1:0]     coin,
    output logic                   pause,
    output logic [8*DIP_BANKS-1:0] dip,
    output logic [3:0]             game_index
);

    localparam int CW = $clog2(COIN_CYCLES + 1);
    localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_CYCLES);

    // Control bit positions, identical to the per-player joystick layout.
    typedef enum logic [3:0] {
        CTL_RIGHT = 4'd0, CTL_LEFT, CTL_DOWN, CTL_UP,
        CTL_B1, CTL_B2, CTL_B3, CTL_START, CTL_COIN
    } ctl_e;

    logic                              prime_q;
    logic                              key_tog_q;
    logic [1:0][8:0]                   key_q, key_d;
    logic                              pause_key_q, pause_key_d;
    logic [4*PLAYERS-1:0]              joy_q, joy_d;
    logic [3*PLAYERS-1:0]              buttons_q, buttons_d;
    logic [PLAYERS-1:0]                start_q, start_d;
    logic [PLAYERS-1:0]                coin_hist_q, coin_hist_d;
    logic [PLAYERS-1:0][CW-1:0]        coin_cnt_q, coin_cnt_d;
    logic                              pause_q, pause_d;
    logic                              pause_hist_q, pause_hist_d;
    logic [DIP_BANKS-1:0][7:0]         dip_q, dip_d;
    logic [3:0]                        game_q, game_d;

    logic                              key_event;
    logic                              key_hit;
    logic                              key_p2;
    ctl_e                              key_ctl;
    logic                              pause_key_hit;
    logic                              dip_we;
    logic                              unused_joy_bits;

    // Until prime_q is set, the toggle copy and edge histories only track inputs.
    assign key_event = prime_q && (ps2_key[10] != key_tog_q);

    always_comb begin
        key_hit       = 1'b0;
        key_p2        = 1'b0;
        key_ctl       = CTL_RIGHT;
        pause_key_hit = 1'b0;
        case (ps2_key[7:0])
            8'h75: begin key_hit = ps2_key[8]; key_ctl = CTL_UP;    end
            8'h72: begin key_hit = ps2_key[8]; key_ctl = CTL_DOWN;  end
            8'h6B: begin key_hit = ps2_key[8]; key_ctl = CTL_LEFT;  end
            8'h74: begin key_hit = ps2_key[8]; key_ctl = CTL_RIGHT; end
            8'h14: begin key_hit = 1'b1; key_ctl = CTL_B1;    end
            8'h11: begin key_hit = 1'b1; key_ctl = CTL_B2;    end
            8'h29: begin key_hit = 1'b1; key_ctl = CTL_B3;    end
            8'h16: begin key_hit = 1'b1; key_ctl = CTL_START; end
            8'h2E: begin key_hit = 1'b1; key_ctl = CTL_COIN;  end
            8'h2D: begin key_hit = 1'b1; key_p2 = 1'b1; key_ctl = CTL_UP;    end
            8'h2B: begin key_hit = 1'b1; key_p2 = 1'b1; key_ctl = CTL_DOWN;  end
            8'h23: begin key_hit = 1'b1; key_p2 = 1'b1; key_ctl = CTL_LEFT;  end
            8'h34: begin key_hit = 1'b1; key_p2 = 1'b1; key_ctl = CTL_RIGHT; end
            8'h1C: begin key_hit = 1'b1; key_p2 = 1'b1; key_ctl = CTL_B1;    end
            8'h1B: begin key_hit = 1'b1; key_p2 = 1'b1; key_ctl = CTL_B2;    end
            8'h15: begin key_hit = 1'b1; key_p2 = 1'b1; key_ctl = CTL_B3;    end
            8'h1E: begin key_hit = 1'b1; key_p2 = 1'b1; key_ctl = CTL_START; end
            8'h36: begin key_hit = 1'b1; key_p2 = 1'b1; key_ctl = CTL_COIN;  end
            8'h4D: pause_key_hit = 1'b1;
            default: ;
        endcase
    end

    assign dip_we = ioctl_wr && (ioctl_index == 16'd254) && (ioctl_addr[26:3] == '0);

    always_comb begin : next_state
        logic [8:0] m;
        logic       up, down, left, right;
        logic       pause_src;
        // NOTE: every variable gets a default before any condition, so no latch is inferred.
        key_d        = key_q;
        pause_key_d  = pause_key_q;
        joy_d        = '0;
        buttons_d    = '0;
        start_d      = '0;
        coin_hist_d  = '0;
        coin_cnt_d   = coin_cnt_q;
        dip_d        = dip_q;
        game_d       = game_q;
        pause_src    = pause_key_q;
        m            = '0;
        up           = 1'b0;
        down         = 1'b0;
        left         = 1'b0;
        right        = 1'b0;

        if (key_event) begin
            if (key_hit) key_d[key_p2][key_ctl] = ps2_key[9];
            if (pause_key_hit) pause_key_d = ps2_key[9];
        end

        for (int p = 0; p < PLAYERS; p++) begin
            m = joystick[32*p +: 9];
            if (p < 2) m = m | key_q[p[0]];
            up    = m[CTL_UP];
            down  = m[CTL_DOWN];
            left  = m[CTL_LEFT];
            right = m[CTL_RIGHT];
            if (SOCD && up && down) begin
                up   = 1'b0;
                down = 1'b0;
            end
            if (SOCD && left && right) begin
                left  = 1'b0;
                right = 1'b0;
            end
            joy_d[4*p +: 4]     = {up, down, right, left};
            buttons_d[3*p +: 3] = m[6:4];
            start_d[p]          = m[CTL_START];
            coin_hist_d[p]      = m[CTL_COIN];
            // A running pulse masks new coin edges; only idle counters reload.
            if (coin_cnt_q[p] != '0)
                coin_cnt_d[p] = coin_cnt_q[p] - CW'(1);
            else if (prime_q && m[CTL_COIN] && !coin_hist_q[p])
                coin_cnt_d[p] = COIN_LOAD;
            pause_src = pause_src | joystick[32*p + 9];
        end

        pause_hist_d = pause_src;
        pause_d      = pause_q ^ (prime_q & pause_src & ~pause_hist_q);

        for (int k = 0; k < DIP_BANKS; k++)
            if (dip_we && (ioctl_addr[2:0] == 3'(k))) dip_d[k] = ioctl_data;

        if (ioctl_wr && (ioctl_index == 16'd1)) game_d = ioctl_data[3:0];
    end

    always_comb begin
        unused_joy_bits = 1'b0;
        for (int p = 0; p < PLAYERS; p++)
            unused_joy_bits = unused_joy_bits ^ (^joystick[32*p + 10 +: 22]);
    end

    always_comb begin
        coin = '0;
        for (int p = 0; p < PLAYERS; p++) coin[p] = (coin_cnt_q[p] != '0);
    end

    // NOTE: the DIP bytes are a small flop bank rather than a RAM, so they take the reset too.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_q      <= 1'b0;
            key_tog_q    <= 1'b0;
            key_q        <= '0;
            pause_key_q  <= 1'b0;
            joy_q        <= '0;
            buttons_q    <= '0;
            start_q      <= '0;
            coin_hist_q  <= '0;
            coin_cnt_q   <= '0;
            pause_q      <= 1'b0;
            pause_hist_q <= 1'b0;
            dip_q        <= '0;
            game_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            prime_q      <= 1'b1;
            key_tog_q    <= ps2_key[10];
            key_q        <= key_d;
            pause_key_q  <= pause_key_d;
            joy_q        <= joy_d;
            buttons_q    <= buttons_d;
            start_q      <= start_d;
            coin_hist_q  <= coin_hist_d;
            coin_cnt_q   <= coin_cnt_d;
            pause_q      <= pause_d;
            pause_hist_q <= pause_hist_d;
            dip_q        <= dip_d;
            game_q       <= game_d;
        end
    end

    assign joy        = joy_q;
    assign buttons    = buttons_q;
    assign start      = start_q;
    assign pause      = pause_q;
    assign dip        = dip_q;
    assign game_index = game_q;

endmodule

// File: tb/tb_arcade_input.sv
// Directed bench for arcade_input: two instances differing only in SOCD share all inputs.
module tb_arcade_input;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [63:0] joystick;
    logic        ioctl_wr;
    logic [15:0] ioctl_index;
    logic [26:0] ioctl_addr;
    logic [7:0]  ioctl_data;

    logic [7:0]  joy, ns_joy;
    logic [5:0]  buttons, ns_buttons;
    logic [1:0]  start, ns_start;
    logic [1:0]  coin, ns_coin;
    logic        pause, ns_pause;
    logic [63:0] dip, ns_dip;
    logic [3:0]  game_index, ns_game_index;

    int errors = 0;
    int checks = 0;
    logic tog;

    always #5 clk = ~clk;

    arcade_input #(.PLAYERS(2), .DIP_BANKS(8), .COIN_CYCLES(16), .SOCD(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joystick),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .joy(joy), .buttons(buttons), .start(start),
        .coin(coin), .pause(pause), .dip(dip), .game_index(game_index)
    );

    arcade_input #(.PLAYERS(2), .DIP_BANKS(8), .COIN_CYCLES(16), .SOCD(1'b0)) dut_ns (
        .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joystick),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .joy(ns_joy), .buttons(ns_buttons), .start(ns_start),
        .coin(ns_coin), .pause(ns_pause), .dip(ns_dip), .game_index(ns_game_index)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
        tog     = ~tog;
        ps2_key = {tog, pressed, ext, code};
    endtask

    task automatic ioctl_write(input logic [15:0] idx, input logic [26:0] addr, input logic [7:0] data);
        ioctl_wr    = 1'b1;
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_data  = data;
        step(1);
        ioctl_wr    = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        step(2);
        checks++; if (joy !== 8'h00) begin errors++; $display("FAIL reset_joy: got %h expected 00", joy); end
        checks++; if (buttons !== 6'h00) begin errors++; $display("FAIL reset_buttons: got %h expected 00", buttons); end
        checks++; if (start !== 2'b00) begin errors++; $display("FAIL reset_start: got %b expected 00", start); end
        checks++; if (coin !== 2'b00) begin errors++; $display("FAIL reset_coin: got %b expected 00", coin); end
        checks++; if (pause !== 1'b0) begin errors++; $display("FAIL reset_pause: got %b expected 0", pause); end
        checks++; if (dip !== 64'h0) begin errors++; $display("FAIL reset_dip: got %h expected 0", dip); end
        checks++; if (game_index !== 4'h0) begin errors++; $display("FAIL reset_game: got %h expected 0", game_index); end
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++; if (joy !== 8'h00) begin errors++; $display("FAIL boot_joy cycle %0d: got %h expected 00", i, joy); end
        end
    endtask

    task automatic test_keys;
        send_key(1'b1, 1'b1, 8'h75);
        step(1);
        checks++; if (joy !== 8'h00) begin errors++; $display("FAIL key_up_early: got %h expected 00", joy); end
        step(1);
        checks++; if (joy !== 8'h08) begin errors++; $display("FAIL key_up: got %h expected 08", joy); end
        send_key(1'b1, 1'b0, 8'h72);
        step(2);
        checks++; if (joy !== 8'h08) begin errors++; $display("FAIL keypad_ignored: got %h expected 08", joy); end
        send_key(1'b0, 1'b1, 8'h75);
        step(2);
        checks++; if (joy !== 8'h00) begin errors++; $display("FAIL key_up_release: got %h expected 00", joy); end
        send_key(1'b1, 1'b0, 8'h1C);
        step(2);
        checks++; if (buttons !== 6'b001000) begin errors++; $display("FAIL p2_b1: got %b expected 001000", buttons); end
        send_key(1'b1, 1'b1, 8'h14);
        step(2);
        checks++; if (buttons !== 6'b001001) begin errors++; $display("FAIL p1_b1_ext: got %b expected 001001", buttons); end
        send_key(1'b0, 1'b0, 8'h1C);
        step(2);
        send_key(1'b0, 1'b0, 8'h14);
        step(2);
        checks++; if (buttons !== 6'b000000) begin errors++; $display("FAIL buttons_release: got %b expected 000000", buttons); end
        send_key(1'b1, 1'b0, 8'h16);
        step(2);
        checks++; if (start !== 2'b01) begin errors++; $display("FAIL p1_start: got %b expected 01", start); end
        send_key(1'b0, 1'b0, 8'h16);
        step(2);
        send_key(1'b1, 1'b0, 8'h2B);
        step(2);
        checks++; if (joy !== 8'h40) begin errors++; $display("FAIL p2_down: got %h expected 40", joy); end
        send_key(1'b0, 1'b0, 8'h2B);
        step(2);
    endtask

    task automatic test_socd;
        joystick = 64'h0000_0000_0000_000C;
        step(1);
        checks++; if (joy !== 8'h00) begin errors++; $display("FAIL socd_ud: got %h expected 00", joy); end
        checks++; if (ns_joy !== 8'h0C) begin errors++; $display("FAIL nosocd_ud: got %h expected 0C", ns_joy); end
        joystick = 64'h0000_0003_0000_0000;
        step(1);
        checks++; if (joy !== 8'h00) begin errors++; $display("FAIL socd_lr_p2: got %h expected 00", joy); end
        checks++; if (ns_joy !== 8'h30) begin errors++; $display("FAIL nosocd_lr_p2: got %h expected 30", ns_joy); end
        joystick = 64'h0000_0000_0000_0008;
        step(1);
        checks++; if (joy !== 8'h08) begin errors++; $display("FAIL joy_up_only: got %h expected 08", joy); end
        joystick = 64'h0000_0000_0000_0004;
        send_key(1'b1, 1'b1, 8'h75);
        step(2);
        checks++; if (joy !== 8'h00) begin errors++; $display("FAIL socd_key_joy: got %h expected 00", joy); end
        checks++; if (ns_joy !== 8'h0C) begin errors++; $display("FAIL nosocd_key_joy: got %h expected 0C", ns_joy); end
        send_key(1'b0, 1'b1, 8'h75);
        joystick = 64'h0;
        step(2);
    endtask

    task automatic test_coin;
        int highs;
        int first;
        int last;
        highs = 0; first = -1; last = -1;
        joystick[8] = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step(1);
            if (coin[0]) begin
                highs++;
                if (first < 0) first = i;
                last = i;
            end
        end
        checks++; if (highs !== 16) begin errors++; $display("FAIL coin_hold_len: got %0d expected 16", highs); end
        checks++; if (first !== 1 || last !== 16) begin errors++; $display("FAIL coin_hold_window: got %0d..%0d expected 1..16", first, last); end
        joystick[8] = 1'b0;
        step(2);
        joystick[8] = 1'b1;
        step(1);
        checks++; if (coin !== 2'b01) begin errors++; $display("FAIL coin_repress_start: got %b expected 01", coin); end
        step(15);
        checks++; if (coin !== 2'b01) begin errors++; $display("FAIL coin_repress_last: got %b expected 01", coin); end
        step(1);
        checks++; if (coin !== 2'b00) begin errors++; $display("FAIL coin_repress_end: got %b expected 00", coin); end
        joystick[8] = 1'b0;
        step(2);
        joystick[8] = 1'b1;
        step(1);
        joystick[8] = 1'b0;
        step(3);
        joystick[8] = 1'b1;
        step(12);
        checks++; if (coin !== 2'b01) begin errors++; $display("FAIL coin_masked_last: got %b expected 01", coin); end
        step(1);
        checks++; if (coin !== 2'b00) begin errors++; $display("FAIL coin_masked_end: got %b expected 00", coin); end
        step(13);
        checks++; if (coin !== 2'b00) begin errors++; $display("FAIL coin_masked_no_repulse: got %b expected 00", coin); end
        joystick[8] = 1'b0;
        step(2);
        joystick[8] = 1'b1;
        step(3);
        checks++; if (coin !== 2'b01) begin errors++; $display("FAIL coin_before_reset: got %b expected 01", coin); end
        reset_n = 1'b0;
        #1;
        checks++; if (coin !== 2'b00) begin errors++; $display("FAIL coin_async_reset: got %b expected 00", coin); end
        step(2);
        reset_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (coin[0]) highs++;
        end
        checks++; if (highs !== 0) begin errors++; $display("FAIL coin_held_through_reset: got %0d high cycles expected 0", highs); end
        joystick[8] = 1'b0;
        step(1);
    endtask

    task automatic test_pause;
        joystick[9] = 1'b1;
        send_key(1'b1, 1'b0, 8'h4D);
        step(1);
        checks++; if (pause !== 1'b1) begin errors++; $display("FAIL pause_first: got %b expected 1", pause); end
        step(3);
        checks++; if (pause !== 1'b1) begin errors++; $display("FAIL pause_once: got %b expected 1", pause); end
        joystick[9] = 1'b0;
        send_key(1'b0, 1'b0, 8'h4D);
        step(3);
        checks++; if (pause !== 1'b1) begin errors++; $display("FAIL pause_release: got %b expected 1", pause); end
        send_key(1'b1, 1'b0, 8'h4D);
        step(1);
        checks++; if (pause !== 1'b1) begin errors++; $display("FAIL pause_key_latency: got %b expected 1", pause); end
        step(1);
        checks++; if (pause !== 1'b0) begin errors++; $display("FAIL pause_key_toggle: got %b expected 0", pause); end
        send_key(1'b0, 1'b0, 8'h4D);
        step(2);
        joystick[41] = 1'b1;
        step(1);
        checks++; if (pause !== 1'b1) begin errors++; $display("FAIL pause_p2_joy: got %b expected 1", pause); end
        joystick[41] = 1'b0;
        step(2);
        joystick[9]  = 1'b1;
        joystick[41] = 1'b1;
        step(3);
        checks++; if (pause !== 1'b0) begin errors++; $display("FAIL pause_dual_edge: got %b expected 0", pause); end
        joystick = 64'h0;
        step(2);
    endtask

    task automatic test_ioctl;
        ioctl_write(16'd254, 27'd2, 8'hA5);
        checks++; if (dip !== 64'h0000_0000_00A5_0000) begin errors++; $display("FAIL dip_bank2: got %h expected 00000000_00A50000", dip); end
        ioctl_write(16'd254, 27'd9, 8'h5A);
        checks++; if (dip !== 64'h0000_0000_00A5_0000) begin errors++; $display("FAIL dip_addr9: got %h expected 00000000_00A50000", dip); end
        ioctl_write(16'd254, 27'd7, 8'h3C);
        checks++; if (dip !== 64'h3C00_0000_00A5_0000) begin errors++; $display("FAIL dip_bank7: got %h expected 3C000000_00A50000", dip); end
        ioctl_write(16'd254, 27'd8, 8'h77);
        checks++; if (dip !== 64'h3C00_0000_00A5_0000) begin errors++; $display("FAIL dip_addr8: got %h expected 3C000000_00A50000", dip); end
        ioctl_write(16'd253, 27'd0, 8'h11);
        checks++; if (dip !== 64'h3C00_0000_00A5_0000) begin errors++; $display("FAIL dip_wrong_index: got %h expected 3C000000_00A50000", dip); end
        ioctl_index = 16'd254; ioctl_addr = 27'd0; ioctl_data = 8'hFF;
        step(1);
        checks++; if (dip !== 64'h3C00_0000_00A5_0000) begin errors++; $display("FAIL dip_no_strobe: got %h expected 3C000000_00A50000", dip); end
        ioctl_write(16'd1, 27'd0, 8'h13);
        checks++; if (game_index !== 4'h3) begin errors++; $display("FAIL game_13: got %h expected 3", game_index); end
        ioctl_write(16'd1, 27'h123, 8'hF7);
        checks++; if (game_index !== 4'h7) begin errors++; $display("FAIL game_last_wins: got %h expected 7", game_index); end
    endtask

    task automatic test_simultaneous;
        send_key(1'b1, 1'b1, 8'h74);
        joystick[40] = 1'b1;
        ioctl_write(16'd1, 27'd5, 8'h05);
        checks++; if (game_index !== 4'h5) begin errors++; $display("FAIL simul_game: got %h expected 5", game_index); end
        checks++; if (coin !== 2'b10) begin errors++; $display("FAIL simul_coin: got %b expected 10", coin); end
        step(1);
        checks++; if (joy !== 8'h02) begin errors++; $display("FAIL simul_right: got %h expected 02", joy); end
        send_key(1'b0, 1'b1, 8'h74);
        joystick = 64'h0;
        step(2);
    endtask

    initial begin
        reset_n     = 1'b0;
        ps2_key     = 11'h775;
        tog         = 1'b1;
        joystick    = 64'h0;
        ioctl_wr    = 1'b0;
        ioctl_index = 16'h0;
        ioctl_addr  = 27'h0;
        ioctl_data  = 8'h0;
        test_reset;
        test_keys;
        test_socd;
        test_coin;
        test_pause;
        test_ioctl;
        test_simultaneous;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arcade_input.md
ARCADE_INPUT -- requirements
Module: arcade_input

Interface
REQ-001 PLAYERS, 2, number of players, legal range 1..4.
REQ-002 DIP_BANKS, 8, number of 8-bit DIP bytes, legal range 1..8.
REQ-003 COIN_CYCLES, 16, coin output high time in clk cycles, minimum 1.
REQ-004 SOCD, 1, 1 = opposite directions cancel, 0 = pass through.
REQ-005 clk  in  1  system clock; all registers on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scan code.
REQ-008 joystick  in  32*PLAYERS  player p at [32p+31:32p]: bit0 right, 1 left, 2 down, 3 up, 4-6 B1-B3, 7 start, 8 coin, 9 pause.
REQ-009 ioctl_wr  in  1  download write strobe.
REQ-010 ioctl_index  in  16  download index.
REQ-011 ioctl_addr  in  27  download byte address.
REQ-012 ioctl_data  in  8  download byte.
REQ-013 joy  out  4*PLAYERS  per player {up,down,right,left} at [4p+3:4p].
REQ-014 buttons  out  3*PLAYERS  per player {B3,B2,B1} at [3p+2:3p].
REQ-015 start  out  PLAYERS  start per player.
REQ-016 coin  out  PLAYERS  stretched coin pulse per player.
REQ-017 pause  out  1  pause toggle state.
REQ-018 dip  out  8*DIP_BANKS  bank k at [8k+7:8k].
REQ-019 game_index  out  4  selected game.

Function
REQ-020 Key event: ps2_key[10] differs from its registered copy; key state is then set to ps2_key[9].
REQ-021 P1 map: up/down/left/right = 75/72/6B/74 with ps2_key[8]=1; B1/B2/B3 = 14/11/29 with ps2_key[8] ignored; start 16; coin 2E.
REQ-022 Arrow codes with ps2_key[8]=0 (keypad) are ignored.
REQ-023 P2 map: up 2D, down 2B, left 23, right 34, B1 1C, B2 1B, B3 15, start 1E, coin 36; key 4D = pause source; players 3-4 have no keyboard map.
REQ-024 Each merged control is the OR of its key state and its joystick bit.
REQ-025 With SOCD=1, up&down both set drives both low; left&right both set drives both low, per player.
REQ-026 joy, buttons and start are registered; latency exactly 1 cycle from a merged-input change.
REQ-027 Coin: rising edge of merged coin loads a per-player counter with COIN_CYCLES; coin is 1 while the counter is nonzero, decrementing each cycle.
REQ-028 Coin edges during an active pulse are ignored; holding coin yields one pulse only; a new pulse needs release and re-press.
REQ-029 Pause: rising edge of the OR of all pause sources toggles pause; simultaneous edges from several sources toggle once.
REQ-030 DIP write: ioctl_wr & ioctl_index==254 & ioctl_addr[26:3]==0 & ioctl_addr[2:0]<DIP_BANKS writes ioctl_data to that bank; any other address is ignored.
REQ-031 game_index write: ioctl_wr & ioctl_index==1 loads ioctl_data[3:0] at any address; last write wins.
REQ-032 A key event, an ioctl write and coin/pause edges in the same cycle all take effect independently.

Reset
REQ-033 reset_n low clears key states, joy, buttons, start, coin, coin counters, pause, dip and game_index to 0, asynchronously.
REQ-034 A prime flag cleared by reset forces the first cycle after release to load the ps2 toggle copy and all edge-history registers from current inputs, with no event or edge generated.
REQ-035 Reset asserted mid-pulse terminates the coin pulse immediately; coin held through reset release does not pulse.

Verification
REQ-036 Release reset with ps2_key=0x775 (toggle 1, pressed, ext, 75) -> joy stays 0 for 10 cycles.
REQ-037 Toggle ps2_key[10] with pressed=1, ext=1, code 75 -> joy[3]=1 exactly one cycle after the event cycle; repeat with ext=0, code 72 -> joy[2] unchanged.
REQ-038 joystick[3:2]=11 with SOCD=1 -> joy[3:2]=00; with SOCD=0 -> joy[3:2]=11.
REQ-039 joystick[8] held 100 cycles, COIN_CYCLES=16 -> coin[0] high exactly 16 cycles then 0; release then re-press -> second 16-cycle pulse.
REQ-040 joystick[9] rises and key 4D press event occur in the same cycle -> pause 0->1 once; next press -> 1->0.
REQ-041 Index 254, addr 2, data A5 -> dip[23:16]=A5; addr 9 with DIP_BANKS=8 -> dip unchanged; index 1, data 13 -> game_index=3.
